// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, frame constants and baud math.
// Used by both the receiver and the transmitter side of the link.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic UART_PARITY_ODD = 1'b1;

    // round(baud * os * 2^acc_w / clk_hz)
    function automatic int unsigned baud_inc(
        input longint unsigned clk_hz,
        input longint unsigned baud,
        input longint unsigned os,
        input longint unsigned acc_w
    );
        longint unsigned num;
        num = (baud * os) << acc_w;
        return 32'((num + (clk_hz >> 1)) / clk_hz);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional baud tick generator: the carry of a free-running accumulator
// marks one oversample tick.
module uart_baud_tick #(
    parameter int unsigned AccWidth = 16,
    parameter int unsigned Inc      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    localparam logic [AccWidth:0] INC_W = (AccWidth + 1)'(Inc);

    logic [AccWidth:0] acc_q;
    logic [AccWidth:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = {1'b0, acc_q[AccWidth-1:0]} + INC_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign tick_o = acc_q[AccWidth] & en_i;

endmodule

// File: rtl/uart_rx_parity.sv
// 16x oversampling UART receiver: 8 data bits, odd parity, one stop bit.
// Reports each frame with a one-cycle strobe plus parity/framing status.
module uart_rx_parity
    import uart_pkg::*;
#(
    parameter int unsigned ClkFrequency = 50000000,
    parameter int unsigned Baud         = 19200,
    parameter int unsigned Oversampling = 16,
    parameter int unsigned BaudAccWidth = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       RxD_parity_error,
    output logic       RxD_frame_error,
    output logic       RxD_busy
);

    localparam int unsigned INC = baud_inc(64'(ClkFrequency), 64'(Baud),
                                           64'(Oversampling), 64'(BaudAccWidth));
    localparam logic [3:0] LAST_BIT = 4'(UART_DATA_BITS - 1);

    logic tick;

    uart_baud_tick #(
        .AccWidth (BaudAccWidth),
        .Inc      (INC)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .tick_o (tick)
    );

    // Synchronizer and filter reset low so a line already low at reset
    // release keeps the receiver in ARM instead of faking a start.
    logic [1:0] sync_q;
    logic [2:0] hist_q;
    logic [2:0] hist_d;
    logic       rx_line;

    assign rx_line = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2])
                   | (hist_q[1] & hist_q[2]);

    always_comb begin
        hist_d = hist_q;
        if (tick) begin
            hist_d = {hist_q[1:0], sync_q[1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[0], RxD};
            hist_q <= hist_d;
        end
    end

    uart_state_e state_q;
    uart_state_e state_d;

    logic [3:0]                cnt_q,   cnt_d;
    logic [3:0]                bit_q,   bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      par_q,   par_d;
    logic [UART_DATA_BITS-1:0] data_q,  data_d;
    logic                      perr_q,  perr_d;
    logic                      ferr_q,  ferr_d;
    logic                      rdy_q,   rdy_d;
    logic                      busy_q,  busy_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            unique case (state_q)
                ST_ARM:    if (rx_line) state_d = ST_IDLE;
                ST_IDLE:   if (!rx_line) state_d = ST_START;
                ST_START:  if (cnt_q == 4'd7) state_d = rx_line ? ST_IDLE : ST_DATA;
                ST_DATA:   if (cnt_q == 4'd15 && bit_q == LAST_BIT) state_d = ST_PARITY;
                ST_PARITY: if (cnt_q == 4'd15) state_d = ST_STOP;
                ST_STOP:   if (cnt_q == 4'd15) state_d = rx_line ? ST_IDLE : ST_ARM;
                default:   state_d = ST_ARM;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        busy_d  = busy_q;
        rdy_d   = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_ARM, ST_IDLE: begin
                    cnt_d = '0;
                    bit_d = '0;
                end
                ST_START: begin
                    if (cnt_q == 4'd7) begin
                        cnt_d  = '0;
                        busy_d = !rx_line;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        shift_d = {rx_line, shift_q[UART_DATA_BITS-1:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end
                ST_PARITY: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) par_d = rx_line;
                end
                ST_STOP: begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        data_d = shift_q;
                        perr_d = (^{shift_q, par_q}) != UART_PARITY_ODD;
                        ferr_d = !rx_line;
                        busy_d = 1'b0;
                        rdy_d  = 1'b1;
                    end
                end
                default: begin
                    cnt_d = '0;
                    bit_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign RxD_data         = data_q;
    assign RxD_data_ready   = rdy_q;
    assign RxD_parity_error = perr_q;
    assign RxD_frame_error  = ferr_q;
    assign RxD_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboard bench for uart_rx_parity at a fast baud (100 clk per bit).
// Expected frames are queued when sent and checked on each strobe.
module tb_uart_rx_parity;

    localparam int unsigned CLK_HZ = 50000000;
    localparam int unsigned BAUD   = 500000;
    localparam int BIT = 100;
    localparam int TICK_TOL = 10;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       RxD_parity_error;
    logic       RxD_frame_error;
    logic       RxD_busy;

    uart_rx_parity #(
        .ClkFrequency (CLK_HZ),
        .Baud         (BAUD),
        .Oversampling (16),
        .BaudAccWidth (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .RxD              (RxD),
        .RxD_data         (RxD_data),
        .RxD_data_ready   (RxD_data_ready),
        .RxD_parity_error (RxD_parity_error),
        .RxD_frame_error  (RxD_frame_error),
        .RxD_busy         (RxD_busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   strobe_t[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    logic prev_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (prev_rdy) check("strobe_1clk", {31'd0, RxD_data_ready}, 0);
        if (RxD_data_ready) begin
            strobe_t.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("spurious_strobe", {24'd0, RxD_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data", {24'd0, RxD_data}, {24'd0, e.d});
                check("parity_err", {31'd0, RxD_parity_error}, {31'd0, e.pe});
                check("frame_err", {31'd0, RxD_frame_error}, {31'd0, e.fe});
                check("busy_at_strobe", {31'd0, RxD_busy}, 0);
            end
        end
        prev_rdy = RxD_data_ready;
    end

    task automatic hold(input logic v, input int n);
        RxD = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int bt);
        hold(1'b0, bt);
        for (int i = 0; i < 8; i++) hold(d[i], bt);
        hold(p, bt);
        hold(s, bt);
    endtask

    // Correct odd-parity bit makes the count of ones in data+parity odd.
    task automatic expect_frame(input logic [7:0] d, input logic p,
                                input logic s);
        exp_t e;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        e.d  = d;
        e.pe = ((ones + int'(p)) % 2) == 0;
        e.fe = !s;
        sb_q.push_back(e);
    endtask

    task automatic frame(input logic [7:0] d, input logic p, input logic s,
                         input int bt);
        expect_frame(d, p, s);
        send_frame(d, p, s, bt);
    endtask

    task automatic check_quiet(input string tag);
        check(tag, sb_q.size(), 0);
    endtask

    task automatic b2b(input int bt);
        int gap;
        strobe_t.delete();
        frame(8'h01, 1'b0, 1'b1, bt);
        frame(8'hFE, 1'b0, 1'b1, bt);
        hold(1'b1, 3 * BIT);
        check("b2b_count", strobe_t.size(), 2);
        if (strobe_t.size() == 2) begin
            gap = strobe_t[1] - strobe_t[0] - 11 * bt;
            if (gap < 0) gap = -gap;
            check("b2b_gap_ok", {31'd0, gap <= TICK_TOL}, 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_data", {24'd0, RxD_data}, 0);
        check("rst_ready", {31'd0, RxD_data_ready}, 0);
        check("rst_perr", {31'd0, RxD_parity_error}, 0);
        check("rst_ferr", {31'd0, RxD_frame_error}, 0);
        check("rst_busy", {31'd0, RxD_busy}, 0);
        rst = 1'b0;
        hold(1'b1, 3 * BIT);

        frame(8'h55, 1'b1, 1'b1, BIT);
        hold(1'b1, 2 * BIT);
        check("busy_after_55", {31'd0, RxD_busy}, 0);
        check_quiet("pending_55");

        frame(8'h07, 1'b1, 1'b1, BIT);
        hold(1'b1, 2 * BIT);
        check_quiet("pending_07");

        frame(8'hA3, 1'b1, 1'b0, BIT);
        hold(1'b0, 3 * BIT);
        check_quiet("pending_A3");
        hold(1'b1, 2 * BIT);
        frame(8'h00, 1'b1, 1'b1, BIT);
        hold(1'b1, 2 * BIT);
        check_quiet("pending_00");

        hold(1'b0, 25);
        hold(1'b1, 2 * BIT);
        check("glitch_busy", {31'd0, RxD_busy}, 0);
        check_quiet("glitch_quiet");
        frame(8'h3C, 1'b1, 1'b1, BIT);
        hold(1'b1, 2 * BIT);
        check_quiet("pending_3C_a");

        fork
            send_frame(8'h81, 1'b1, 1'b1, BIT);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                check("busy_midframe", {31'd0, RxD_busy}, 1);
                rst = 1'b1;
                #1;
                check("mrst_data", {24'd0, RxD_data}, 0);
                check("mrst_busy", {31'd0, RxD_busy}, 0);
                check("mrst_ready", {31'd0, RxD_data_ready}, 0);
                check("mrst_flags", {30'd0, RxD_parity_error, RxD_frame_error}, 0);
                repeat (3) @(negedge clk);
                rst = 1'b0;
            end
        join
        hold(1'b1, 2 * BIT);
        check_quiet("after_81");
        frame(8'h3C, 1'b1, 1'b1, BIT);
        hold(1'b1, 2 * BIT);
        check_quiet("pending_3C_b");

        b2b(BIT + BIT / 50);
        b2b(BIT - BIT / 50);

        hold(1'b1, 2 * BIT);
        check_quiet("final_queue");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
